// File: rtl/score_keeper.sv
// ---------------------------------------------------------------------------
// score_keeper
//   Sums the per-enemy-type score increments into a saturating binary game
//   score, awards a bomb each time the score passes a BOMB_STEP multiple, and
//   converts the score to BCD digits with a sequential double-dabble FSM
//   (one bit per clock) for the on-screen score renderer.
//
// Ports
//   clk_vga       in   pixel/system clock
//   rst           in   asynchronous active-high reset
//   clr_i         in   synchronous game restart; clears all score state
//   en_i          in   accumulation enable (game running)
//   add_score1_i  in   increment from enemy type 1
//   add_score2_i  in   increment from enemy type 2
//   add_score3_i  in   increment from enemy type 3
//   score_o       out  registered binary score, saturates at SCORE_MAX
//   bcd_o         out  BCD score, digit 0 in bits [3:0]
//   bcd_valid_o   out  one-cycle pulse when bcd_o updates
//   busy_o        out  high while a conversion is in progress
//   bomb_award_o  out  one-cycle pulse per bomb granted
// ---------------------------------------------------------------------------
module score_keeper #(
   parameter int ADD_WIDTH   = 8,
   parameter int SCORE_WIDTH = 20,
   parameter int DIGITS      = 6,
   parameter int SCORE_MAX   = 999999,
   parameter int BOMB_STEP   = 1000
) (
   input  logic                   clk_vga,
   input  logic                   rst,
   input  logic                   clr_i,
   input  logic                   en_i,
   input  logic [ADD_WIDTH-1:0]   add_score1_i,
   input  logic [ADD_WIDTH-1:0]   add_score2_i,
   input  logic [ADD_WIDTH-1:0]   add_score3_i,
   output logic [SCORE_WIDTH-1:0] score_o,
   output logic [4*DIGITS-1:0]    bcd_o,
   output logic                   bcd_valid_o,
   output logic                   busy_o,
   output logic                   bomb_award_o
);

   localparam int CNT_W = $clog2(SCORE_WIDTH);
   localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(SCORE_WIDTH - 1);
   localparam logic [SCORE_WIDTH-1:0] MAX_S  = SCORE_WIDTH'(SCORE_MAX);
   localparam logic [SCORE_WIDTH:0]   MAX_X  = (SCORE_WIDTH+1)'(SCORE_MAX);
   localparam logic [SCORE_WIDTH:0]   STEP_X = (SCORE_WIDTH+1)'(BOMB_STEP);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [SCORE_WIDTH-1:0] r_score;
   logic [SCORE_WIDTH:0]   r_threshold;   // one extra bit: may pass SCORE_MAX
   logic [SCORE_WIDTH-1:0] r_snapshot;
   logic [4*DIGITS-1:0]    r_shift;
   logic [CNT_W-1:0]       r_cnt;
   logic [4*DIGITS-1:0]    r_bcd;
   logic                   r_valid;
   logic                   r_bomb;

   logic [ADD_WIDTH+1:0]   w_sum;
   logic [SCORE_WIDTH:0]   w_total;
   logic [SCORE_WIDTH-1:0] w_score_next;
   logic [SCORE_WIDTH:0]   w_score_x;
   logic                   w_award;
   logic [4*DIGITS-1:0]    w_adj;
   logic [4*DIGITS-1:0]    w_shift_next;
   logic                   w_latch;
   logic                   w_step;
   logic                   w_done;

   // Accumulation, widened so neither the sum nor the compare can wrap.
   assign w_sum        = {2'b00, add_score1_i} + {2'b00, add_score2_i} + {2'b00, add_score3_i};
   assign w_total      = {1'b0, r_score} + {{(SCORE_WIDTH-ADD_WIDTH-1){1'b0}}, w_sum};
   assign w_score_next = (w_total > MAX_X) ? MAX_S : w_total[SCORE_WIDTH-1:0];

   // A threshold above SCORE_MAX can never be reached, so awards stop there.
   assign w_score_x = {1'b0, r_score};
   assign w_award   = (w_score_x >= r_threshold) && (r_threshold <= MAX_X);

   // Double-dabble: correct every nibble >= 5, then shift in the next bit.
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
         assign w_adj[gi*4 +: 4] = (r_shift[gi*4 +: 4] >= 4'd5) ?
                                   r_shift[gi*4 +: 4] + 4'd3 : r_shift[gi*4 +: 4];
      end
   endgenerate

   assign w_shift_next = {w_adj[4*DIGITS-2:0], r_snapshot[LAST_BIT - r_cnt]};

   always_comb begin
      w_state_next = r_state;
      w_latch      = 1'b0;
      w_step       = 1'b0;
      w_done       = 1'b0;
      if (!clr_i) begin
         case (r_state)
            S_IDLE: begin
               if (r_score != r_snapshot) begin
                  w_latch      = 1'b1;
                  w_state_next = S_SHIFT;
               end
            end
            S_SHIFT: begin
               w_step = 1'b1;
               if (r_cnt == LAST_BIT) w_state_next = S_DONE;
            end
            S_DONE: begin
               w_done       = 1'b1;
               w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
         endcase
      end else begin
         w_state_next = S_IDLE;
      end
   end

   always_ff @(posedge clk_vga or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk_vga or posedge rst) begin
      if (rst) begin
         r_score     <= '0;
         r_threshold <= STEP_X;
         r_snapshot  <= '0;
         r_shift     <= '0;
         r_cnt       <= '0;
         r_bcd       <= '0;
         r_valid     <= 1'b0;
         r_bomb      <= 1'b0;
      end else if (clr_i) begin
         r_score     <= '0;
         r_threshold <= STEP_X;
         r_snapshot  <= '0;
         r_shift     <= '0;
         r_cnt       <= '0;
         r_bcd       <= '0;
         r_valid     <= 1'b0;
         r_bomb      <= 1'b0;
      end else begin
         if (en_i) r_score <= w_score_next;

         r_bomb <= w_award;
         if (w_award) r_threshold <= r_threshold + STEP_X;

         if (w_latch) begin
            r_snapshot <= r_score;
            r_shift    <= '0;
            r_cnt      <= '0;
         end
         if (w_step) begin
            r_shift <= w_shift_next;
            r_cnt   <= r_cnt + CNT_W'(1);
         end

         r_valid <= w_done;
         if (w_done) r_bcd <= r_shift;
      end
   end

   assign score_o      = r_score;
   assign bcd_o        = r_bcd;
   assign bcd_valid_o  = r_valid;
   assign busy_o       = (r_state != S_IDLE);
   assign bomb_award_o = r_bomb;

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

   localparam int ADD_WIDTH   = 8;
   localparam int SCORE_WIDTH = 20;
   localparam int DIGITS      = 6;
   localparam int SCORE_MAX   = 999999;
   localparam int BOMB_STEP   = 1000;
   localparam int BCD_LAT     = SCORE_WIDTH + 2;

   logic                   clk_vga = 1'b0;
   logic                   rst;
   logic                   clr_i;
   logic                   en_i;
   logic [ADD_WIDTH-1:0]   add_score1_i;
   logic [ADD_WIDTH-1:0]   add_score2_i;
   logic [ADD_WIDTH-1:0]   add_score3_i;
   logic [SCORE_WIDTH-1:0] score_o;
   logic [4*DIGITS-1:0]    bcd_o;
   logic                   bcd_valid_o;
   logic                   busy_o;
   logic                   bomb_award_o;

   int checks = 0;
   int errors = 0;

   score_keeper #(
      .ADD_WIDTH(ADD_WIDTH), .SCORE_WIDTH(SCORE_WIDTH), .DIGITS(DIGITS),
      .SCORE_MAX(SCORE_MAX), .BOMB_STEP(BOMB_STEP)
   ) dut (
      .clk_vga(clk_vga), .rst(rst), .clr_i(clr_i), .en_i(en_i),
      .add_score1_i(add_score1_i), .add_score2_i(add_score2_i), .add_score3_i(add_score3_i),
      .score_o(score_o), .bcd_o(bcd_o), .bcd_valid_o(bcd_valid_o),
      .busy_o(busy_o), .bomb_award_o(bomb_award_o)
   );

   always #5 clk_vga = ~clk_vga;

   typedef struct {
      bit clr;
      bit en;
      int a1;
      int a2;
      int a3;
      int exp_score;
      bit exp_bomb;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit en, input int a1, input int a2, input int a3, input bit clr);
      en_i         = en;
      add_score1_i = ADD_WIDTH'(a1);
      add_score2_i = ADD_WIDTH'(a2);
      add_score3_i = ADD_WIDTH'(a3);
      clr_i        = clr;
   endtask

   task automatic tick();
      @(posedge clk_vga);
      #1;
   endtask

   task automatic do_clear();
      drive(0, 0, 0, 0, 1);
      tick();
      drive(0, 0, 0, 0, 0);
   endtask

   // Decimal digits of v, least significant digit in the low nibble.
   function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
      logic [4*DIGITS-1:0] r;
      int x;
      r = '0;
      x = v;
      for (int d = 0; d < DIGITS; d++) begin
         r[d*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   initial begin
      int lat, pulses, model, s, p1, p2, p3, ms, aw, idx;
      bit mb, rc, re;
      int ra1, ra2, ra3;
      logic [4*DIGITS-1:0] first_bcd;
      logic [4*DIGITS-1:0] seen[$];
      int hist[$];

      rst = 1'b1;
      drive(0, 0, 0, 0, 0);
      tick(); tick();
      check("reset_score", score_o, 0);
      check("reset_bcd", bcd_o, 0);
      check("reset_valid", bcd_valid_o, 0);
      check("reset_busy", busy_o, 0);
      check("reset_bomb", bomb_award_o, 0);
      rst = 1'b0;
      tick();

      // Single increment of 10 and its conversion latency.
      drive(1, 0, 0, 10, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      check("add10_score", score_o, 10);
      lat = -1; pulses = 0; first_bcd = '0;
      for (int n = 1; n <= 40; n++) begin
         tick();
         if (n == 1) check("add10_busy_start", busy_o, 1);
         if (bcd_valid_o) begin
            pulses++;
            if (lat < 0) begin
               lat = n;
               first_bcd = bcd_o;
            end
         end
      end
      check("add10_latency", lat, BCD_LAT);
      check("add10_bcd", first_bcd, 24'h000010);
      check("add10_pulses", pulses, 1);
      check("add10_busy_end", busy_o, 0);

      // Accumulation and bomb table.
      vecs.push_back('{0, 1, 100, 60, 10, 170, 0});
      vecs.push_back('{0, 1, 100, 60, 10, 340, 0});
      vecs.push_back('{0, 1, 100, 60, 10, 510, 0});
      vecs.push_back('{0, 1, 100, 60, 10, 680, 0});
      vecs.push_back('{0, 1, 100, 60, 10, 850, 0});
      vecs.push_back('{0, 1, 100, 60, 10, 1020, 0});
      vecs.push_back('{0, 0, 9, 9, 9, 1020, 1});
      vecs.push_back('{0, 0, 0, 0, 0, 1020, 0});
      vecs.push_back('{0, 1, 255, 255, 255, 1785, 0});
      vecs.push_back('{0, 1, 255, 255, 255, 2550, 0});
      vecs.push_back('{0, 0, 7, 7, 7, 2550, 1});
      vecs.push_back('{0, 0, 0, 0, 0, 2550, 0});
      vecs.push_back('{1, 1, 50, 50, 50, 0, 0});
      vecs.push_back('{0, 1, 255, 255, 255, 765, 0});
      vecs.push_back('{0, 1, 255, 255, 255, 1530, 0});
      vecs.push_back('{0, 1, 255, 255, 255, 2295, 1});
      vecs.push_back('{0, 1, 255, 255, 255, 3060, 1});
      vecs.push_back('{0, 0, 0, 0, 0, 3060, 1});
      vecs.push_back('{0, 0, 0, 0, 0, 3060, 0});
      vecs.push_back('{0, 0, 0, 0, 0, 3060, 0});
      do_clear();
      tick();
      foreach (vecs[i]) begin
         drive(vecs[i].en, vecs[i].a1, vecs[i].a2, vecs[i].a3, vecs[i].clr);
         tick();
         check($sformatf("vec%0d_score", i), score_o, vecs[i].exp_score);
         check($sformatf("vec%0d_bomb", i), bomb_award_o, vecs[i].exp_bomb);
      end
      drive(0, 0, 0, 0, 0);

      // Score changes while a conversion is in flight: two pulses, in order.
      do_clear();
      drive(1, 0, 0, 10, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      for (int n = 0; n < 5; n++) tick();
      check("midshift_busy", busy_o, 1);
      drive(1, 0, 0, 10, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      seen.delete();
      for (int n = 0; n < 70; n++) begin
         tick();
         if (bcd_valid_o) seen.push_back(bcd_o);
      end
      check("retrigger_pulses", seen.size(), 2);
      if (seen.size() >= 2) begin
         check("retrigger_first", seen[0], 24'h000010);
         check("retrigger_second", seen[1], 24'h000020);
      end

      // clr_i mid-conversion, with an increment present in the same cycle.
      do_clear();
      drive(1, 0, 0, 10, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      for (int n = 0; n < 6; n++) tick();
      drive(1, 50, 0, 0, 1);
      tick();
      drive(0, 0, 0, 0, 0);
      check("clr_score", score_o, 0);
      check("clr_bcd", bcd_o, 0);
      check("clr_busy", busy_o, 0);
      check("clr_valid", bcd_valid_o, 0);
      pulses = 0;
      for (int n = 0; n < 30; n++) begin
         tick();
         if (bcd_valid_o) pulses++;
      end
      check("clr_no_pulse", pulses, 0);

      // Saturation at SCORE_MAX.
      do_clear();
      model = 0;
      for (int n = 0; n < 2000 && model < 999990; n++) begin
         s  = (999990 - model > 765) ? 765 : 999990 - model;
         p1 = (s > 255) ? 255 : s;
         p2 = (s - p1 > 255) ? 255 : s - p1;
         p3 = s - p1 - p2;
         drive(1, p1, p2, p3, 0);
         tick();
         model += s;
      end
      drive(0, 0, 0, 0, 0);
      check("preload_score", score_o, 999990);
      drive(1, 10, 10, 10, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      check("sat_score", score_o, SCORE_MAX);
      for (int n = 0; n < 100; n++) tick();
      check("sat_bcd", bcd_o, 24'h999999);
      check("sat_busy", busy_o, 0);
      drive(1, 10, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      check("sat_hold", score_o, SCORE_MAX);
      pulses = 0;
      for (int n = 0; n < 30; n++) begin
         tick();
         if (bcd_valid_o) pulses++;
      end
      check("sat_no_pulse", pulses, 0);

      // Asynchronous reset in the middle of a conversion.
      do_clear();
      drive(1, 0, 0, 10, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      for (int n = 0; n < 4; n++) tick();
      #2;
      rst = 1'b1;
      #1;
      check("arst_score", score_o, 0);
      check("arst_bcd", bcd_o, 0);
      check("arst_valid", bcd_valid_o, 0);
      check("arst_busy", busy_o, 0);
      check("arst_bomb", bomb_award_o, 0);
      tick();
      rst = 1'b0;
      pulses = 0;
      for (int n = 0; n < 30; n++) begin
         tick();
         if (bcd_valid_o) pulses++;
      end
      check("arst_no_pulse", pulses, 0);

      // Randomized run against a behavioural model.
      do_clear();
      ms = 0; aw = 0;
      hist.delete();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rc  = ($urandom_range(0, 299) == 0);
         re  = ($urandom_range(0, 9) == 0);
         ra1 = $urandom_range(0, 255);
         ra2 = $urandom_range(0, 255);
         ra3 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 9);
         drive(re, ra1, ra2, ra3, rc);
         if (rc) begin
            ms = 0; aw = 0; mb = 0;
         end else begin
            // Bombs owed = multiples of BOMB_STEP reached, capped at SCORE_MAX.
            mb = (aw < ((ms < SCORE_MAX ? ms : SCORE_MAX) / BOMB_STEP)) &&
                 (aw < SCORE_MAX / BOMB_STEP);
            if (mb) aw++;
            if (re) ms = (ms + ra1 + ra2 + ra3 > SCORE_MAX) ? SCORE_MAX : ms + ra1 + ra2 + ra3;
         end
         tick();
         hist.push_back(ms);
         check($sformatf("rnd%0d_score", cyc), score_o, ms);
         check($sformatf("rnd%0d_bomb", cyc), bomb_award_o, mb);
         if (bcd_valid_o) begin
            idx = hist.size() - 1 - BCD_LAT;
            if (idx >= 0) check($sformatf("rnd%0d_bcd", cyc), bcd_o, to_bcd(hist[idx]));
            else check($sformatf("rnd%0d_early_valid", cyc), 1, 0);
         end
      end
      drive(0, 0, 0, 0, 0);
      for (int n = 0; n < 60; n++) tick();
      check("rnd_final_bcd", bcd_o, to_bcd(ms));
      check("rnd_final_busy", busy_o, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
